// File: rtl/display_pkg.sv
// display_pkg
// Shared constants and types for the 4-digit 7-segment display scanner.
//   DIGIT_COUNT  : number of multiplexed digits on the board
//   ANODE_OFF    : active-low anode pattern with every digit dark
//   selector_t   : digit index fed to the display multiplexer
//   scan_state_t : DRIVE (digit strobed) / BLANK (inter-digit dead time)
package display_pkg;

    localparam int         DIGIT_COUNT = 4;
    localparam logic [3:0] ANODE_OFF   = 4'b1111;

    typedef logic [1:0] selector_t;

    typedef enum logic {
        DRIVE = 1'b0,
        BLANK = 1'b1
    } scan_state_t;

endpackage

// File: rtl/tick_divider.sv
// tick_divider
// Modulo-N cycle counter with count enable and terminal-count pulse.
// Ports:
//   clock : system clock, rising edge
//   reset : asynchronous, active-high; clears the count to 0
//   en    : count enable; the count holds while low
//   tc    : high during the enabled cycle in which the count is N-1
//           (the count wraps to 0 on that edge)
module tick_divider #(
    parameter int unsigned N = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic en,
    output logic tc
);

    // Keep at least one bit so N = 1 still elaborates (tc then fires every enabled cycle).
    localparam int unsigned W    = (N > 1) ? $clog2(N) : 1;
    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] count_reg;

    assign tc = en && (count_reg == LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else if (en) begin
            count_reg <= tc ? '0 : count_reg + 1'b1;
        end
    end

endmodule

// File: rtl/display_scanner.sv
// display_scanner
// Time-multiplexing driver for the Basys3 4-digit 7-segment display.
// Generates the digit selector for the downstream multiplexer and the
// matching active-low anode strobe; digits whose mask bit is clear are
// skipped in the scan order.
// Ports:
//   clock      : system clock, rising edge
//   reset      : asynchronous, active-high
//   enable     : 1 = scanning; 0 = display dark, scan state frozen
//   digit_mask : bit i set = digit i takes part in the scan
//   selector   : index of the scanned digit (registered)
//   anode      : active-low one-hot digit strobe (registered, at most one low)
//   scan_tick  : one-cycle pulse on every selector update (period end)
// Build option:
//   DISPLAY_SCANNER_BLANK_EN : inserts BLANK_TICKS cycles of dark anodes
//                              after every period end (BLANK state).
module display_scanner
    import display_pkg::*;
#(
    parameter int unsigned TICKS_PER_DIGIT = 100000,
    parameter int unsigned BLANK_TICKS     = 1000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] digit_mask,
    output logic [1:0] selector,
    output logic [3:0] anode,
    output logic       scan_tick
);

    scan_state_t state_reg;
    scan_state_t state_next;
    selector_t   sel_reg;
    selector_t   sel_next;
    logic [3:0]  anode_reg;
    logic [3:0]  anode_next;
    logic        scan_tick_reg;
    logic        period_en;
    logic        period_tc;

    // Nearest set mask bit after cur, searching cur+1, cur+2, cur+3 (mod 4).
    // Scanning from the farthest candidate down lets the nearest one win.
    // Falls back to cur when no other digit is enabled.
    function automatic selector_t next_digit(input selector_t cur, input logic [3:0] mask);
        selector_t cand;
        next_digit = cur;
        for (int k = DIGIT_COUNT - 1; k >= 1; k--) begin
            cand = cur + selector_t'(k);
            if (mask[cand]) begin
                next_digit = cand;
            end
        end
    endfunction

    // The period counter only advances while a digit is being driven.
    assign period_en = enable && (state_reg == DRIVE);

    tick_divider #(
        .N(TICKS_PER_DIGIT)
    ) u_period (
        .clock(clock),
        .reset(reset),
        .en   (period_en),
        .tc   (period_tc)
    );

`ifdef DISPLAY_SCANNER_BLANK_EN
    logic blank_en;
    logic blank_tc;

    assign blank_en = enable && (state_reg == BLANK);

    tick_divider #(
        .N(BLANK_TICKS)
    ) u_blank (
        .clock(clock),
        .reset(reset),
        .en   (blank_en),
        .tc   (blank_tc)
    );
`else
    // Dead time is not built in; BLANK_TICKS has no effect here.
    logic unused_blank_ticks;
    assign unused_blank_ticks = (BLANK_TICKS > 0);
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg     <= DRIVE;
            sel_reg       <= '0;
            anode_reg     <= ANODE_OFF;
            scan_tick_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            sel_reg       <= sel_next;
            anode_reg     <= anode_next;
            scan_tick_reg <= period_tc;
        end
    end

    always_comb begin
        state_next = state_reg;
        sel_next   = sel_reg;
        anode_next = ANODE_OFF;

        if (period_tc) begin
            sel_next = next_digit(sel_reg, digit_mask);
        end

`ifdef DISPLAY_SCANNER_BLANK_EN
        case (state_reg)
            DRIVE:   if (period_tc) state_next = BLANK;
            BLANK:   if (blank_tc)  state_next = DRIVE;
            default: state_next = DRIVE;
        endcase
`else
        state_next = DRIVE;
`endif

        // Anode is computed from the next selector so selector and strobe
        // always change on the same edge.
        if (enable && digit_mask[sel_next] && (state_next == DRIVE)) begin
            anode_next = ~(4'b0001 << sel_next);
        end
    end

    assign selector  = sel_reg;
    assign anode     = anode_reg;
    assign scan_tick = scan_tick_reg;

endmodule

// File: tb/tb_display_scanner.sv
// tb_display_scanner
// Self-checking bench for display_scanner with TICKS_PER_DIGIT=4, BLANK_TICKS=2.
// A cycle-level reference model derived from the scan rules is advanced on
// every clock edge and compared against selector/anode/scan_tick; scenario
// tasks add directed checks on run lengths, tick spacing and freezing.
// Build option: DISPLAY_SCANNER_BLANK_EN (must match the RTL build).
module tb_display_scanner;

    localparam int T = 4;
    localparam int B = 2;
`ifdef DISPLAY_SCANNER_BLANK_EN
    localparam bit BLANK_MODE = 1'b1;
    localparam int PER        = T + B;
`else
    localparam bit BLANK_MODE = 1'b0;
    localparam int PER        = T;
`endif

    logic       clk;
    logic       reset;
    logic       enable;
    logic [3:0] digit_mask;
    logic [1:0] selector;
    logic [3:0] anode;
    logic       scan_tick;

    int vectors;
    int miscompares;

    // Reference model state
    int         m_cnt;
    int         m_bcnt;
    int         m_sel;
    bit         m_blank;
    logic [3:0] m_anode;
    logic       m_tick;

    display_scanner #(
        .TICKS_PER_DIGIT(T),
        .BLANK_TICKS    (B)
    ) dut (
        .clock     (clk),
        .reset     (reset),
        .enable    (enable),
        .digit_mask(digit_mask),
        .selector  (selector),
        .anode     (anode),
        .scan_tick (scan_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_reset();
        m_cnt   = 0;
        m_bcnt  = 0;
        m_sel   = 0;
        m_blank = 1'b0;
        m_anode = 4'b1111;
        m_tick  = 1'b0;
    endfunction

    // One clock edge of the scan rules, using the inputs present at the edge.
    function automatic void model_clock();
        bit         pend;
        bit         bend;
        logic [3:0] one_hot;
        pend = enable && !m_blank && (m_cnt == T - 1);
        bend = enable && m_blank && (m_bcnt == B - 1);
        if (enable && !m_blank) m_cnt = pend ? 0 : m_cnt + 1;
        if (enable && m_blank)  m_bcnt = bend ? 0 : m_bcnt + 1;
        if (pend) begin
            int pick;
            pick = m_sel;
            for (int k = 1; k <= 3; k++) begin
                if (pick == m_sel && digit_mask[(m_sel + k) % 4]) pick = (m_sel + k) % 4;
            end
            m_sel = pick;
        end
        m_tick = pend;
        if (BLANK_MODE) begin
            if (pend)      m_blank = 1'b1;
            else if (bend) m_blank = 1'b0;
        end
        one_hot = 4'b0001 << m_sel;
        m_anode = (enable && digit_mask[m_sel] && !m_blank) ? ~one_hot : 4'b1111;
    endfunction

    // Advance one clock, update the model, compare all outputs 1 time unit later.
    task automatic step();
        @(posedge clk);
        if (reset) model_reset();
        else       model_clock();
        #1;
        vectors++;
        if (anode !== m_anode || selector !== m_sel[1:0] || scan_tick !== m_tick) begin
            miscompares++;
            $display("FAIL model t=%0t: anode=%b sel=%0d tick=%b, expected anode=%b sel=%0d tick=%b",
                     $time, anode, selector, scan_tick, m_anode, m_sel, m_tick);
        end
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        enable     = 1'b0;
        digit_mask = 4'b0000;
        #1;
        vectors++;
        if (anode !== 4'b1111 || selector !== 2'd0 || scan_tick !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_async: anode=%b sel=%0d tick=%b, expected 1111/0/0", anode, selector, scan_tick);
        end
        model_reset();
        step();
        step();
        reset = 1'b0;
        $display("test_reset: done");
    endtask

    task automatic test_full_scan();
        int last;
        int ticks;
        int sel_before;
        enable     = 1'b1;
        digit_mask = 4'b1111;
        last  = -1;
        ticks = 0;
        for (int i = 0; i < 4 * PER + 1; i++) begin
            sel_before = selector;
            step();
            if (scan_tick === 1'b1) begin
                ticks++;
                vectors++;
                if (last < 0 && i != T - 1) begin
                    miscompares++;
                    $display("FAIL first_tick: at step %0d, expected step %0d", i, T - 1);
                end else if (last >= 0 && i - last != PER) begin
                    miscompares++;
                    $display("FAIL tick_spacing: %0d cycles, expected %0d", i - last, PER);
                end
                vectors++;
                if (selector !== 2'((sel_before + 1) % 4)) begin
                    miscompares++;
                    $display("FAIL scan_order: sel=%0d, expected %0d", selector, (sel_before + 1) % 4);
                end
                last = i;
            end
        end
        vectors++;
        if (ticks != 4) begin
            miscompares++;
            $display("FAIL full_scan_ticks: %0d, expected 4", ticks);
        end
        $display("test_full_scan: %0d ticks", ticks);
    endtask

    task automatic test_mask_0101();
        int prev;
        digit_mask = 4'b0101;
        prev = -1;
        for (int i = 0; i < 5 * PER; i++) begin
            step();
            vectors++;
            if (anode[1] !== 1'b1 || anode[3] !== 1'b1) begin
                miscompares++;
                $display("FAIL mask0101_strobe: anode=%b, digits 1/3 must stay dark", anode);
            end
            if (scan_tick === 1'b1) begin
                vectors++;
                if ((selector !== 2'd0 && selector !== 2'd2) || (prev >= 0 && int'(selector) == prev)) begin
                    miscompares++;
                    $display("FAIL mask0101_sel: sel=%0d prev=%0d, expected alternating 0/2", selector, prev);
                end
                prev = selector;
            end
        end
        $display("test_mask_0101: done");
    endtask

    task automatic test_mask_zero();
        int ticks;
        logic [1:0] sel0;
        digit_mask = 4'b0000;
        sel0  = selector;
        ticks = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (scan_tick === 1'b1) ticks++;
            vectors++;
            if (anode !== 4'b1111 || selector !== sel0) begin
                miscompares++;
                $display("FAIL mask_zero: anode=%b sel=%0d, expected 1111 sel=%0d", anode, selector, sel0);
            end
        end
        vectors++;
        if (ticks != 12 / PER) begin
            miscompares++;
            $display("FAIL mask_zero_ticks: %0d, expected %0d", ticks, 12 / PER);
        end
        $display("test_mask_zero: %0d ticks", ticks);
    endtask

    task automatic test_enable_freeze();
        bit         seen_tick;
        bit         found;
        logic [3:0] prev_anode;
        int         more;
        digit_mask = 4'b1111;
        enable     = 1'b1;
        seen_tick  = 1'b0;
        found      = 1'b0;
        prev_anode = anode;
        for (int i = 0; i < 10 * PER && !found; i++) begin
            step();
            if (scan_tick === 1'b1) seen_tick = 1'b1;
            if (seen_tick && anode === 4'b1101 && prev_anode !== 4'b1101) found = 1'b1;
            prev_anode = anode;
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL freeze_wait: digit 1 never started, anode=%b", anode);
        end
        step();
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            vectors++;
            if (anode !== 4'b1111 || selector !== 2'd1) begin
                miscompares++;
                $display("FAIL freeze_hold: anode=%b sel=%0d, expected 1111 sel=1", anode, selector);
            end
        end
        enable = 1'b1;
        more   = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (anode !== 4'b1101) break;
            more++;
        end
        vectors++;
        if (more != T - 2 || selector !== 2'd2) begin
            miscompares++;
            $display("FAIL freeze_resume: %0d more cycles then sel=%0d, expected %0d then sel=2", more, selector, T - 2);
        end
        $display("test_enable_freeze: resumed for %0d cycles", more);
    endtask

    task automatic test_async_reset();
        bit found;
        int n;
        digit_mask = 4'b1111;
        enable     = 1'b1;
        found      = 1'b0;
        for (int i = 0; i < 10 * PER && !found; i++) begin
            step();
            if (selector === 2'd2 && anode === 4'b1011) found = 1'b1;
        end
        step();
        #2;
        reset = 1'b1;
        #1;
        vectors++;
        if (!found || anode !== 4'b1111 || selector !== 2'd0 || scan_tick !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: found=%0d anode=%b sel=%0d tick=%b, expected 1111/0/0",
                     found, anode, selector, scan_tick);
        end
        model_reset();
        step();
        step();
        reset = 1'b0;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (scan_tick === 1'b1) begin
                n = i;
                break;
            end
        end
        vectors++;
        if (n != T) begin
            miscompares++;
            $display("FAIL reset_fresh_period: first tick after %0d cycles, expected %0d", n, T);
        end
        $display("test_async_reset: first tick after %0d cycles", n);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) digit_mask = 4'($urandom_range(0, 15));
            enable = ($urandom_range(0, 9) != 0);
            step();
        end
        $display("test_random: 400 cycles");
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        model_reset();
        test_reset();
        test_full_scan();
        test_mask_0101();
        test_mask_zero();
        test_enable_freeze();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
